// File: rtl/stream_io_pkg.sv
// stream_io_pkg: shared constants and helpers for the stream I/O shell.
// FloPoCo exception-field encoding and pointer-width helper.
package stream_io_pkg;

  localparam logic [1:0] EF_ZERO = 2'b00;
  localparam logic [1:0] EF_NORM = 2'b01;
  localparam logic [1:0] EF_INF  = 2'b10;
  localparam logic [1:0] EF_NAN  = 2'b11;

  // Exception field from the exponent/mantissa of an IEEE-754 single.
  // The sign bit does not affect the class, so it is not passed in.
  function automatic logic [1:0] fpc_ef(input logic [30:0] p);
    logic [7:0]  e;
    logic [22:0] m;
    e = p[30:23];
    m = p[22:0];
    if (e == 8'h00 && m == 23'd0) return EF_ZERO;
    if (e == 8'hFF) return (m == 23'd0) ? EF_INF : EF_NAN;
    return EF_NORM;
  endfunction

  // Pointer width for a power-of-2 depth of at least 2.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// stream_sync_fifo: single-clock FIFO, no fall-through.
// Head entry is presented directly from storage.
module stream_sync_fifo
  import stream_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ptr_w(DEPTH):0] o_count
);

  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/stream_io_shell.sv
// stream_io_shell: host <-> kernel stream wrapper.
// Input skid with EF append, output FIFO with EF strip, debug stats.
module stream_io_shell
  import stream_io_pkg::*;
#(
  parameter  int STREAMW     = 32,
  parameter  int NIN         = 4,
  parameter  int NOUT        = 4,
  parameter  int FPC_EN      = 1,
  parameter  int FPC_MODE    = 0,
  parameter  int OFIFO_DEPTH = 4,
  localparam int KW = (FPC_EN != 0) ? STREAMW + 2 : STREAMW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ivalid,
  output logic                    iready,
  input  logic [NIN*STREAMW-1:0]  in_data,
  output logic                    ovalid,
  input  logic                    oready,
  output logic [NOUT*STREAMW-1:0] out_data,
  output logic                    k_ivalid,
  input  logic                    k_iready,
  output logic [NIN*KW-1:0]       k_in_data,
  input  logic                    k_ovalid,
  output logic                    k_oready,
  input  logic [NOUT*KW-1:0]      k_out_data,
  input  logic                    clr_stats,
  output logic [31:0]             in_count,
  output logic [31:0]             out_count,
  output logic                    exc_sticky
);

  localparam int IW  = NIN * STREAMW;
  localparam int OW  = NOUT * STREAMW;
  localparam int OAW = ptr_w(OFIFO_DEPTH);

  logic [IW-1:0]   r_sk [2];
  logic            r_sk_wp;
  logic            r_sk_rp;
  logic [1:0]      r_sk_cnt;
  logic [1:0]      w_sk_cnt_n;
  logic            r_iready;
  logic            w_acc;
  logic            w_kpop;
  logic [IW-1:0]   w_head;

  logic            r_koready;
  logic            w_kpush;
  logic            w_opop;
  logic            w_full;
  logic            w_empty;
  logic [OAW:0]    w_ocnt;
  logic [OAW:0]    w_ocnt_n;
  logic [OW-1:0]   w_strip;
  logic [NOUT-1:0] w_exc_l;

  logic [31:0]     r_in_cnt;
  logic [31:0]     r_out_cnt;
  logic            r_exc;

  assign iready     = r_iready;
  assign k_ivalid   = (r_sk_cnt != 2'd0);
  assign w_acc      = ivalid & r_iready;
  assign w_kpop     = k_ivalid & k_iready;
  assign w_sk_cnt_n = r_sk_cnt + 2'(w_acc) - 2'(w_kpop);
  assign w_head     = r_sk[r_sk_rp];

  // Skid storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_acc) r_sk[r_sk_wp] <= in_data;
  end

  // Skid pointers, occupancy and registered input ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sk_wp  <= 1'b0;
      r_sk_rp  <= 1'b0;
      r_sk_cnt <= 2'd0;
      r_iready <= 1'b0;
    end else begin
      if (w_acc)  r_sk_wp <= ~r_sk_wp;
      if (w_kpop) r_sk_rp <= ~r_sk_rp;
      r_sk_cnt <= w_sk_cnt_n;
      r_iready <= (w_sk_cnt_n < 2'd2);
    end
  end

  for (genvar g = 0; g < NIN; g++) begin : g_in
    logic [STREAMW-1:0] w_pl;
    assign w_pl = w_head[g*STREAMW +: STREAMW];
    if (FPC_EN != 0) begin : g_ef
      logic [1:0] w_ef;
      if (FPC_MODE != 0) begin : g_ieee
        assign w_ef = fpc_ef(w_pl[30:0]);
      end else begin : g_const
        assign w_ef = EF_NORM;
      end
      assign k_in_data[g*KW +: KW] = {w_ef, w_pl};
    end else begin : g_raw
      assign k_in_data[g*KW +: KW] = w_pl;
    end
  end

  for (genvar g = 0; g < NOUT; g++) begin : g_out
    assign w_strip[g*STREAMW +: STREAMW] = k_out_data[g*KW +: STREAMW];
    if (FPC_EN != 0) begin : g_ef
      logic [1:0] w_ef;
      assign w_ef       = k_out_data[g*KW+STREAMW +: 2];
      assign w_exc_l[g] = (w_ef == EF_INF) || (w_ef == EF_NAN);
    end else begin : g_raw
      assign w_exc_l[g] = 1'b0;
    end
  end

  assign k_oready = r_koready & ~w_full;
  assign w_kpush  = k_ovalid & k_oready;
  assign ovalid   = ~w_empty;
  assign w_opop   = ovalid & oready;
  assign w_ocnt_n = w_ocnt + (OAW+1)'(w_kpush) - (OAW+1)'(w_opop);

  stream_sync_fifo #(
    .WIDTH (OW),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_kpush),
    .i_wdata (w_strip),
    .i_pop   (w_opop),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_ocnt)
  );

  // Kernel-side ready from next FIFO occupancy, held low in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_koready <= 1'b0;
    else      r_koready <= (w_ocnt_n < (OAW+1)'(OFIFO_DEPTH));
  end

  assign in_count   = r_in_cnt;
  assign out_count  = r_out_cnt;
  assign exc_sticky = r_exc;

  // Beat counters and sticky exception; clear wins over updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_cnt  <= 32'd0;
      r_out_cnt <= 32'd0;
      r_exc     <= 1'b0;
    end else if (clr_stats) begin
      r_in_cnt  <= 32'd0;
      r_out_cnt <= 32'd0;
      r_exc     <= 1'b0;
    end else begin
      if (w_acc)  r_in_cnt  <= r_in_cnt + 32'd1;
      if (w_opop) r_out_cnt <= r_out_cnt + 32'd1;
      if (w_kpush && (|w_exc_l)) r_exc <= 1'b1;
    end
  end

endmodule
